mor1kx_wb_stage_cappuccino: RTL

Writeback stage of the cappuccino pipeline, directly upstream of the register file's write port.
- Registers the retiring control-stage instruction and selects its result (ALU, load, multiply, mfspr).
- Performs big-endian load lane extraction and extension, then drives the RF write signals (result, destination address, write enable).
- Optionally sweeps zeros into every GPR after reset before releasing the pipeline.

---
 rtl/mor1kx_wb_stage_cappuccino_pkg.sv | 13 +
 rtl/mor1kx_lsu_load_ext.sv | 39 +++
 rtl/mor1kx_wb_stage_cappuccino.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mor1kx_wb_stage_cappuccino_pkg.sv
// Shared encodings for the cappuccino writeback stage and its load extender.
package mor1kx_wb_stage_cappuccino_pkg;

  // Load size as carried by ctrl_lsu_length_i; 2'b11 is treated as a word.
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Writeback controller states.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/mor1kx_lsu_load_ext.sv
// Big-endian load lane extraction with sign/zero extension (32-bit bus).
// Byte address 0 is bits [31:24]. Half-word accesses ignore adr_i[0] because
// misalignment is trapped before the load reaches this point.
module mor1kx_lsu_load_ext
  import mor1kx_wb_stage_cappuccino_pkg::*;
(
  input  logic [31:0] dat_i,
  input  logic [1:0]  length_i,
  input  logic        zext_i,
  input  logic [1:0]  adr_i,
  output logic [31:0] dat_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte and half-word lanes.
  always_comb begin
    byte_lane = dat_i[31:24];
    case (adr_i)
      2'd0:    byte_lane = dat_i[31:24];
      2'd1:    byte_lane = dat_i[23:16];
      2'd2:    byte_lane = dat_i[15:8];
      default: byte_lane = dat_i[7:0];
    endcase
    half_lane = adr_i[1] ? dat_i[15:0] : dat_i[31:16];
  end

  // Extend the selected lane to the full word; words pass through untouched.
  always_comb begin
    dat_o = dat_i;
    case (length_i)
      LEN_BYTE: dat_o = {{24{~zext_i & byte_lane[7]}}, byte_lane};
      LEN_HALF: dat_o = {{16{~zext_i & half_lane[15]}}, half_lane};
      default:  dat_o = dat_i;
    endcase
  end

endmodule

// File: rtl/mor1kx_wb_stage_cappuccino.sv
// Cappuccino writeback stage: registers the retiring control-stage result and
// drives the register-file write port. Optionally zeroes every GPR after reset.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_INIT | zero sweep: one GPR write per cycle, pipeline held via busy
// ST_RUN  | normal retire: one-cycle write pulse per advancing instruction
module mor1kx_wb_stage_cappuccino
  import mor1kx_wb_stage_cappuccino_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH     = 32,
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_WORDS          = 32,
  parameter int OPTION_RF_CLEAR_ON_RESET = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            padv_ctrl_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
  input  logic                            ctrl_exception_i,
  input  logic                            ctrl_op_lsu_load_i,
  input  logic                            ctrl_op_mul_i,
  input  logic                            ctrl_op_mfspr_i,
  input  logic [1:0]                      ctrl_lsu_length_i,
  input  logic                            ctrl_lsu_zext_i,
  input  logic [1:0]                      ctrl_lsu_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_lsu_dat_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_mul_result_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_mfspr_dat_i,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
  output logic                            rf_init_busy_o
);

  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int DW = OPTION_OPERAND_WIDTH;
  localparam logic [AW-1:0] LAST_ADR  = AW'(OPTION_RF_WORDS - 1);
  localparam logic [0:0]    RST_STATE = (OPTION_RF_CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wb_q, wb_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] load_dat;
  logic [DW-1:0] sel_result;

  mor1kx_lsu_load_ext u_load_ext (
    .dat_i    (ctrl_lsu_dat_i),
    .length_i (ctrl_lsu_length_i),
    .zext_i   (ctrl_lsu_zext_i),
    .adr_i    (ctrl_lsu_adr_i),
    .dat_o    (load_dat)
  );

  // Result priority: load lane, multiply, mfspr, then ALU.
  always_comb begin
    sel_result = ctrl_alu_result_i;
    if (ctrl_op_lsu_load_i)
      sel_result = load_dat;
    else if (ctrl_op_mul_i)
      sel_result = ctrl_mul_result_i;
    else if (ctrl_op_mfspr_i)
      sel_result = ctrl_mfspr_dat_i;
  end

  // Next-state: zero sweep in INIT; in RUN the write enable is a single-cycle
  // pulse while address and data hold until the next retiring instruction.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wb_d     = 1'b0;
    adr_d    = adr_q;
    result_d = result_q;
    case (state_q)
      ST_INIT: begin
        wb_d     = 1'b1;
        adr_d    = cnt_q;
        result_d = '0;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == LAST_ADR)
          state_d = ST_RUN;
      end
      default: begin
        if (padv_ctrl_i && !pipeline_flush_i) begin
          wb_d     = ctrl_rf_wb_i & ~ctrl_exception_i;
          adr_d    = ctrl_rfd_adr_i;
          result_d = sel_result;
        end
      end
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      wb_q     <= 1'b0;
      adr_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_q     <= wb_d;
      adr_q    <= adr_d;
      result_q <= result_d;
    end
  end

  assign wb_rf_wb_o     = wb_q;
  assign wb_rfd_adr_o   = adr_q;
  assign result_o       = result_q;
  assign rf_init_busy_o = (state_q == ST_INIT);

endmodule
